// File: rtl/bound_flasher_gen.sv
// bound_flasher_gen: thermometer lamp bar that fills and drains through three bounces with flick kickbacks.
// Optional flick latch: define BOUND_FLASHER_FLICK_LATCH_EN to capture flick pulses that land between steps.
module bound_flasher_gen #(
    parameter int NUM_LP    = 16,
    parameter int KB_CNT    = 5,
    parameter int PEAK2_CNT = 11,
    parameter int PEAK3_CNT = 6,
    parameter int CW        = $clog2(NUM_LP + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step_i,
    input  logic              flick_i,
    output logic [NUM_LP-1:0] lamp_o,
    output logic [CW-1:0]     count_o,
    output logic [2:0]        state_o,
    output logic              busy_o,
    output logic              done_o
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UP1  = 3'd1,
        DN1  = 3'd2,
        UP2  = 3'd3,
        DN2  = 3'd4,
        UP3  = 3'd5,
        DN3  = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_up, cnt_dn;
    logic [NUM_LP-1:0] lamp_q;
    logic              busy_q, done_q, done_d, flick_eff;

    assign cnt_up = cnt_q + 1'b1;
    assign cnt_dn = cnt_q - 1'b1;

`ifdef BOUND_FLASHER_FLICK_LATCH_EN
    logic flag_q;
    // remember any flick seen since the last step; every step consumes the flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flag_q <= 1'b0;
        else        flag_q <= !step_i && (flag_q || flick_i);
    end
    assign flick_eff = flick_i | flag_q;
`else
    assign flick_eff = flick_i;
`endif

    // next count/state; nothing moves without a step except recovery from the unused code
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (step_i) begin
                state_d = flick_eff ? UP1 : IDLE;
                cnt_d   = flick_eff ? CW'(1) : '0;
            end
            UP1: if (step_i) begin
                cnt_d = cnt_up;
                if (cnt_up == CW'(NUM_LP)) state_d = DN1;
            end
            DN1: if (step_i) begin
                cnt_d = cnt_dn;
                if (cnt_dn == CW'(KB_CNT)) state_d = flick_eff ? UP1 : UP2;
            end
            UP2: if (step_i) begin
                cnt_d = cnt_up;
                if (cnt_up == CW'(PEAK2_CNT)) state_d = DN2;
            end
            DN2: if (step_i) begin
                cnt_d = cnt_dn;
                if (cnt_dn == CW'(KB_CNT) && flick_eff) state_d = UP2;
                else if (cnt_dn == '0)                  state_d = flick_eff ? UP2 : UP3;
            end
            UP3: if (step_i) begin
                cnt_d = cnt_up;
                if (cnt_up == CW'(PEAK3_CNT)) state_d = DN3;
            end
            DN3: if (step_i) begin
                cnt_d = cnt_dn;
                if (cnt_dn == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // all outputs registered from next-state so lamp, count, state and busy change on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lamp_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lamp_q  <= ~({NUM_LP{1'b1}} << cnt_d);
            busy_q  <= state_d != IDLE;
            done_q  <= done_d;
        end
    end

    assign lamp_o  = lamp_q;
    assign count_o = cnt_q;
    assign state_o = state_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
endmodule

// File: tb/tb_bound_flasher_gen.sv
// tb_bound_flasher_gen: random and directed stimulus against a phase/count reference model, two parameter sets.
module tb_bound_flasher_gen;
`ifdef BOUND_FLASHER_FLICK_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif
    logic        clk = 1'b0, rst_n = 1'b1, step = 1'b0, flick = 1'b0;
    logic [15:0] lamp;
    logic [4:0]  count;
    logic [2:0]  state;
    logic        busy, done;
    logic [7:0]  lamp_b;
    logic [3:0]  count_b;
    logic [2:0]  state_b;
    logic        busy_b, done_b;
    int checks = 0, failures = 0;

    int m_n[2]  = '{16, 8};
    int m_kb[2] = '{5, 2};
    int m_p2[2] = '{11, 5};
    int m_p3[2] = '{6, 3};
    int mc[2], mp[2];
    bit md[2];
    bit mflag;

    always #5 clk = ~clk;

    bound_flasher_gen dut (
        .clk(clk), .rst_n(rst_n), .step_i(step), .flick_i(flick),
        .lamp_o(lamp), .count_o(count), .state_o(state), .busy_o(busy), .done_o(done)
    );

    bound_flasher_gen #(.NUM_LP(8), .KB_CNT(2), .PEAK2_CNT(5), .PEAK3_CNT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .step_i(step), .flick_i(flick),
        .lamp_o(lamp_b), .count_o(count_b), .state_o(state_b), .busy_o(busy_b), .done_o(done_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int peak(input int k, input int p);
        return p == 1 ? m_n[k] : p == 3 ? m_p2[k] : m_p3[k];
    endfunction

    // phases: 0 idle, odd = filling toward a peak, even = draining
    task automatic model_clk(input bit s, input bit f);
        bit fe;
        fe = f | (LATCH & mflag);
        mflag = LATCH & !s & (mflag | f);
        for (int k = 0; k < 2; k++) begin
            md[k] = 1'b0;
            if (s) begin
                if (mp[k] == 0) begin
                    if (fe) begin mc[k] = 1; mp[k] = 1; end
                end else if (mp[k] % 2 == 1) begin
                    mc[k]++;
                    if (mc[k] == peak(k, mp[k])) mp[k]++;
                end else begin
                    mc[k]--;
                    if (mp[k] == 2 && mc[k] == m_kb[k]) mp[k] = fe ? 1 : 3;
                    else if (mp[k] == 4 && mc[k] == m_kb[k] && fe) mp[k] = 3;
                    else if (mp[k] == 4 && mc[k] == 0) mp[k] = fe ? 3 : 5;
                    else if (mp[k] == 6 && mc[k] == 0) begin mp[k] = 0; md[k] = 1'b1; end
                end
            end
        end
    endtask

    task automatic compare();
        chk("lamp",    64'(lamp),    (64'd1 << mc[0]) - 64'd1);
        chk("count",   64'(count),   64'(mc[0]));
        chk("state",   64'(state),   64'(mp[0]));
        chk("busy",    64'(busy),    64'(mp[0] != 0));
        chk("done",    64'(done),    64'(md[0]));
        chk("lamp_b",  64'(lamp_b),  (64'd1 << mc[1]) - 64'd1);
        chk("count_b", 64'(count_b), 64'(mc[1]));
        chk("state_b", 64'(state_b), 64'(mp[1]));
        chk("busy_b",  64'(busy_b),  64'(mp[1] != 0));
        chk("done_b",  64'(done_b),  64'(md[1]));
    endtask

    task automatic cyc(input bit s, input bit f);
        step = s;
        flick = f;
        model_clk(s, f);
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        step = 1'b0;
        flick = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        mc = '{0, 0};
        mp = '{0, 0};
        md = '{0, 0};
        mflag = 1'b0;
        compare();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int a_at, b_at, a_pulses;
        #1 rst_n = 1'b0;
        mc = '{0, 0};
        mp = '{0, 0};
        md = '{0, 0};
        mflag = 1'b0;
        @(negedge clk);
        compare();
        rst_n = 1'b1;
        a_at = -1;
        b_at = -1;
        a_pulses = 0;
        for (int i = 1; i <= 80; i++) begin
            cyc(1'b1, i == 1);
            if (done) a_pulses++;
            if (done && a_at < 0) a_at = i;
            if (done_b && b_at < 0) b_at = i;
        end
        chk("done_at_a", 64'(a_at), 64'd56);
        chk("done_at_b", 64'(b_at), 64'd28);
        chk("done_pulses_a", 64'(a_pulses), 64'd1);
        chk("final_lamp_a", 64'(lamp), 64'd0);
        do_reset();
        for (int i = 1; i <= 27; i++) cyc(1'b1, i == 1 || i == 27);
        chk("dn1_kick_state", 64'(state), 64'd1);
        chk("dn1_kick_count", 64'(count), 64'd5);
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0);
        chk("dn1_refill_state", 64'(state), 64'd2);
        chk("dn1_refill_count", 64'(count), 64'd15);
        do_reset();
        for (int i = 1; i <= 56; i++) begin
            cyc(1'b1, i == 1 || i == 39 || i == 56);
            if (i == 39) chk("dn2_kb_state", 64'(state), 64'd3);
        end
        chk("dn2_zero_state", 64'(state), 64'd3);
        chk("dn2_zero_count", 64'(count), 64'd0);
        for (int i = 0; i < 11; i++) cyc(1'b1, 1'b0);
        chk("dn2_zero_peak", 64'(count), 64'd11);
        do_reset();
        for (int i = 1; i <= 30; i++) cyc(1'b1, i == 1);
        chk("mid_up2_count", 64'(count), 64'd8);
        chk("mid_up2_state", 64'(state), 64'd3);
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
        chk("post_reset_busy", 64'(busy), 64'd0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        chk("between_flick", 64'(state), 64'(LATCH));
        for (int i = 0; i < 600; i++) cyc(i % 3 == 0, $urandom_range(0, 11) == 0);
        do_reset();
        for (int i = 0; i < 4000; i++) cyc($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
        do_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bound_flasher_gen.md
Name: bound_flasher_gen

Overview:
- Parametrised next-generation bound flasher.
- Drives a thermometer-coded lamp bar of NUM_LP lamps that fills and drains, one lamp per step, through a three-bounce sequence with flick-controlled kickbacks.
- Adds over the previous generation: generic lamp count and bounce points, a step strobe that decouples lamp speed from clk, status outputs (busy/done/count), and an optional flick latch.
- Sits between the board timer (step) and the lamp driver pins.

Parameters:
- NUM_LP, 16: number of lamps; legal range 4..64.
- KB_CNT, 5: kickback level (lit-lamp count) checked in DN1 and DN2; 1 <= KB_CNT < PEAK2_CNT.
- PEAK2_CNT, 11: top level of the second fill; PEAK2_CNT <= NUM_LP.
- PEAK3_CNT, 6: top level of the third fill; 1 <= PEAK3_CNT <= NUM_LP.
- CW, $clog2(NUM_LP+1): width of the count port; derived, do not override.

Ports:
- clk  input  1  clock; all flops on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- step  input  1  advance strobe; the sequence moves only on cycles with step=1. Tie high for one move per clk.
- flick  input  1  start/kickback request; sampled only on step cycles.
- lamp  output  NUM_LP  lamp bar, registered; lamp[i]=1 iff i < count.
- count  output  CW  number of lit lamps, registered.
- state  output  3  current state code, registered.
- busy  output  1  1 when state != IDLE.
- done  output  1  one-clk pulse when the sequence completes.

Behaviour:
- Core register is the count c. lamp is derived from c and is always thermometer coded. Each step changes c by exactly +1 (UP states) or -1 (DN states).
- Reset values, asynchronous: c=0, lamp=0, state=IDLE, busy=0, done=0, flick latch=0. Reset mid-sequence aborts immediately to these values; no completion pulse.
- With step=0, all state is held. done is forced 0 on non-step cycles.
- State codes:
  - IDLE=0
  - UP1=1
  - DN1=2
  - UP2=3
  - DN2=4
  - UP3=5
  - DN3=6
  - Code 7 is unreachable and recovers to IDLE with c=0 on the next clk.
- Transitions, evaluated on step cycles. "Reaches X" means the value of c after this step. F is flick, or the effective flick when the optional feature is compiled in.
  - IDLE: if F, then c=1 and go to UP1. Otherwise hold with c=0.
  - UP1: c+1. When c reaches NUM_LP, go to DN1. F is ignored.
  - DN1: c-1. When c reaches KB_CNT: if F, go to UP1; otherwise go to UP2.
  - UP2: c+1. When c reaches PEAK2_CNT, go to DN2. F is ignored.
  - DN2: c-1.
    - When c reaches KB_CNT with F=1, go to UP2.
    - When c reaches KB_CNT with F=0, stay in DN2.
    - When c reaches 0: if F, go to UP2; otherwise go to UP3.
  - UP3: c+1. When c reaches PEAK3_CNT, go to DN3. F is ignored.
  - DN3: c-1. When c reaches 0, go to IDLE and assert done for the single clk after that edge.
- No latency beyond one clk: lamp, count and state update on the same edge as the step.
- c never leaves the range 0..NUM_LP.
- Back-to-back operation: a flick in IDLE on the step cycle immediately after done starts a new run.

Optional Feature:
- Macro: BOUND_FLASHER_FLICK_LATCH_EN.
- Defined: a sticky flag is set on any clk with flick=1. Effective F = flick | flag. The flag is cleared on every step cycle, including a step that sets it again in the same cycle from flick=1. This captures short flick pulses that occur between slow steps.
- Not defined: F = flick sampled on step cycles only; flick pulses between steps are lost.

Test Plan:
- Defaults, step=1, flick=1 for one step in IDLE then 0 -> count sequence 1..16, 15..5, 6..11, 10..0, 1..6, 5..0. done pulses exactly once, after the 56th step. Final state=IDLE, lamp=0.
- Flick=1 on the DN1 step reaching count 5 -> state returns to UP1, count 6..16 again, then DN1 repeats.
- Flick=1 on the DN2 step reaching count 5 -> UP2 (count 6..11). Flick=1 on the DN2 step reaching count 0 -> UP2 (count 1..11), with no entry to UP3.
- step toggles 1/0 with a 3-clk period -> lamp changes only after step cycles. A 1-clk flick pulse between steps is lost without BOUND_FLASHER_FLICK_LATCH_EN and honoured with it.
- rst_n asserted low mid-UP2 at count 8 -> lamp=0, count=0, state=IDLE, busy=0 asynchronously. No done pulse. A restart after release behaves normally.
- NUM_LP=8, KB_CNT=2, PEAK2_CNT=5, PEAK3_CNT=3, flick pulsed at start only -> peaks 8, 5, 3; done after 8+6+3+5+3+3=28 steps.
